// File: rtl/adma_pkg.sv
// Shared types for the ADMA channel scheduler: FSM states,
// channel-id width helper and the latched command bundle.
package adma_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam int CMD_CHN_MAX  = 8;
    localparam int CMD_ADDR_MAX = 64;
    localparam int CMD_LEN_MAX  = 16;

    function automatic int chn_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the widest supported build; the top uses the low bits.
    typedef struct packed {
        logic [CMD_CHN_MAX-1:0]  chn;
        logic [CMD_ADDR_MAX-1:0] addr;
        logic [CMD_LEN_MAX-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/adma_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns a one-hot grant and the binary index of the winner.
module adma_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    // Walk from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/adma_chn_sched.sv
// ADMA channel scheduler: round-robin issue of per-channel read commands.
// Optional priority class enabled by defining ADMA_SCHED_PRIO_EN.
module adma_chn_sched
    import adma_pkg::*;
#(
    parameter int DST_CHANNEL_NUM  = 4,
    parameter int ADDR_W           = 32,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int MAX_OUTSTD       = 4,
    localparam int CHN_ID_W        = chn_id_w(DST_CHANNEL_NUM)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DST_CHANNEL_NUM-1:0]  req_valid_i,
    input  logic [ADDR_W-1:0]           req_addr_i [DST_CHANNEL_NUM],
    input  logic [TRANS_DATA_LEN_W-1:0] req_len_i  [DST_CHANNEL_NUM],
`ifdef ADMA_SCHED_PRIO_EN
    input  logic [DST_CHANNEL_NUM-1:0]  prio_i,
`endif
    output logic [DST_CHANNEL_NUM-1:0]  req_ready_o,
    output logic                        cmd_valid_o,
    input  logic                        cmd_ready_i,
    output logic [CHN_ID_W-1:0]         cmd_chn_o,
    output logic [ADDR_W-1:0]           cmd_addr_o,
    output logic [TRANS_DATA_LEN_W-1:0] cmd_len_o,
    input  logic                        cpl_valid_i,
    input  logic [CHN_ID_W-1:0]         cpl_chn_i,
    output logic [DST_CHANNEL_NUM-1:0]  busy_o,
    output logic                        idle_o,
    output logic                        cpl_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

    state_t                     state;
    cmd_t                       cmd_q;
    logic [CHN_ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]           cnt;
    logic [DST_CHANNEL_NUM-1:0] busy;
    logic                       err_q;

    logic [DST_CHANNEL_NUM-1:0] elig;
    logic [DST_CHANNEL_NUM-1:0] pick_req;
    logic [DST_CHANNEL_NUM-1:0] pick_gnt;
    logic [CHN_ID_W-1:0]        pick_idx;
    logic                       pick_any;
    logic                       hs;
    logic                       cpl_hit;
    logic [DST_CHANNEL_NUM-1:0] cpl_mask;
    logic [DST_CHANNEL_NUM-1:0] iss_mask;
    logic [CHN_ID_W-1:0]        cur_chn;
    logic [CHN_ID_W-1:0]        nxt_ptr;
    logic                       cmd_unused;

    assign elig = (cnt < CNT_W'(MAX_OUTSTD)) ? (req_valid_i & ~busy) : '0;

`ifdef ADMA_SCHED_PRIO_EN
    // Priority channels shadow the rest; RR still runs inside each class.
    assign pick_req = |(elig & prio_i) ? (elig & prio_i) : elig;
`else
    assign pick_req = elig;
`endif

    adma_rr_pick #(
        .N (DST_CHANNEL_NUM),
        .W (CHN_ID_W)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign pick_any = |pick_gnt;
    assign cur_chn  = cmd_q.chn[CHN_ID_W-1:0];
    assign hs       = (state == S_ISSUE) && cmd_ready_i;
    assign cpl_hit  = cpl_valid_i
                      && (int'(cpl_chn_i) < DST_CHANNEL_NUM)
                      && busy[cpl_chn_i];
    assign cpl_mask = cpl_hit ? (DST_CHANNEL_NUM'(1) << cpl_chn_i) : '0;
    assign iss_mask = hs ? (DST_CHANNEL_NUM'(1) << cur_chn) : '0;
    assign nxt_ptr  = (int'(cur_chn) == DST_CHANNEL_NUM - 1)
                      ? '0 : cur_chn + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= S_IDLE;
            cmd_q  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            busy   <= '0;
            err_q  <= 1'b0;
        end else begin
            busy <= (busy & ~cpl_mask) | iss_mask;
            cnt  <= cnt + CNT_W'(hs) - CNT_W'(cpl_hit);
            if (cpl_valid_i && !cpl_hit) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        cmd_q.chn  <= CMD_CHN_MAX'(pick_idx);
                        cmd_q.addr <= CMD_ADDR_MAX'(req_addr_i[pick_idx]);
                        cmd_q.len  <= CMD_LEN_MAX'(req_len_i[pick_idx]);
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready_i) begin
                        rr_ptr <= nxt_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid_o = (state == S_ISSUE);
    assign cmd_chn_o   = cur_chn;
    assign cmd_addr_o  = cmd_q.addr[ADDR_W-1:0];
    assign cmd_len_o   = cmd_q.len[TRANS_DATA_LEN_W-1:0];
    assign req_ready_o = iss_mask;
    assign busy_o      = busy;
    assign idle_o      = (state == S_IDLE) && (cnt == '0);
    assign cpl_err_o   = err_q;
    assign cmd_unused  = ^cmd_q;

endmodule

// File: tb/tb_adma_chn_sched.sv
// Self-checking bench: two schedulers (MAX_OUTSTD 4 and 2) against a
// cycle-level behavioural model, plus directed literal expectations.
module tb_adma_chn_sched;

    localparam int N = 4;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [31:0]      req_addr [N];
    logic [7:0]       req_len  [N];
    logic [N-1:0]     prio = '0;
    logic [1:0]       cmd_ready = '0;
    logic             cpl_valid = 1'b0;
    logic [1:0]       cpl_chn = '0;

    logic [1:0][N-1:0] req_ready;
    logic [1:0][N-1:0] busy;
    logic [1:0]        cmd_valid;
    logic [1:0]        idle;
    logic [1:0]        err;
    logic [1:0][1:0]   cchn;
    logic [1:0][31:0]  caddr;
    logic [1:0][7:0]   clen;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 aclk = ~aclk;

    adma_chn_sched #(.DST_CHANNEL_NUM(4), .ADDR_W(32),
                     .TRANS_DATA_LEN_W(8), .MAX_OUTSTD(4)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .req_valid_i(req_valid),
        .req_addr_i(req_addr), .req_len_i(req_len),
`ifdef ADMA_SCHED_PRIO_EN
        .prio_i(prio),
`endif
        .req_ready_o(req_ready[0]), .cmd_valid_o(cmd_valid[0]),
        .cmd_ready_i(cmd_ready[0]), .cmd_chn_o(cchn[0]),
        .cmd_addr_o(caddr[0]), .cmd_len_o(clen[0]),
        .cpl_valid_i(cpl_valid), .cpl_chn_i(cpl_chn),
        .busy_o(busy[0]), .idle_o(idle[0]), .cpl_err_o(err[0]));

    adma_chn_sched #(.DST_CHANNEL_NUM(4), .ADDR_W(32),
                     .TRANS_DATA_LEN_W(8), .MAX_OUTSTD(2)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .req_valid_i(req_valid),
        .req_addr_i(req_addr), .req_len_i(req_len),
`ifdef ADMA_SCHED_PRIO_EN
        .prio_i(prio),
`endif
        .req_ready_o(req_ready[1]), .cmd_valid_o(cmd_valid[1]),
        .cmd_ready_i(cmd_ready[1]), .cmd_chn_o(cchn[1]),
        .cmd_addr_o(caddr[1]), .cmd_len_o(clen[1]),
        .cpl_valid_i(cpl_valid), .cpl_chn_i(cpl_chn),
        .busy_o(busy[1]), .idle_o(idle[1]), .cpl_err_o(err[1]));

    // Behavioural model: one pending command, busy set, counter, pointer.
    typedef struct {
        bit         pend;
        int         chn;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [N-1:0] busy;
        int         cnt;
        int         ptr;
        bit         err;
    } mdl_t;

    mdl_t m [2];
    int   maxo [2] = '{4, 2};

    function automatic void mreset(int i);
        m[i].pend = 0; m[i].chn = 0; m[i].addr = '0; m[i].len = '0;
        m[i].busy = '0; m[i].cnt = 0; m[i].ptr = 0; m[i].err = 0;
    endfunction

    function automatic void mstep(int i);
        mdl_t o = m[i];
        logic [N-1:0] pv;
        bit ok;
        int w;
`ifdef ADMA_SCHED_PRIO_EN
        pv = prio;
`else
        pv = '0;
`endif
        ok = cpl_valid && o.busy[cpl_chn];
        if (cpl_valid && !ok) m[i].err = 1;
        if (ok) begin
            m[i].busy[cpl_chn] = 1'b0;
            m[i].cnt--;
        end
        if (o.pend) begin
            if (cmd_ready[i]) begin
                m[i].busy[o.chn] = 1'b1;
                m[i].cnt++;
                m[i].ptr = (o.chn + 1) % N;
                m[i].pend = 0;
            end
        end else if (o.cnt < maxo[i]) begin
            w = -1;
            for (int pass = 0; pass < 2; pass++)
                for (int k = 0; k < N; k++) begin
                    int c = (o.ptr + k) % N;
                    if (w < 0 && req_valid[c] && !o.busy[c]
                        && (pass == 1 || pv[c])) w = c;
                end
            if (w >= 0) begin
                m[i].pend = 1;
                m[i].chn = w;
                m[i].addr = req_addr[w];
                m[i].len = req_len[w];
            end
        end
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mreset(0); mreset(1);
        end else begin
            mstep(0); mstep(1);
        end
    end

    function automatic void chk(string nm, int i, logic [63:0] a,
                                logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, a, e);
        end
    endfunction

    // Every-cycle compare against the model, mid-low-phase.
    always @(negedge aclk) begin
        #2;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [N-1:0] er;
                er = (m[i].pend && cmd_ready[i]) ? N'(1 << m[i].chn) : '0;
                chk("cmd_valid", i, 64'(cmd_valid[i]), 64'(m[i].pend));
                if (m[i].pend) begin
                    chk("cmd_chn", i, 64'(cchn[i]), 64'(m[i].chn));
                    chk("cmd_addr", i, 64'(caddr[i]), 64'(m[i].addr));
                    chk("cmd_len", i, 64'(clen[i]), 64'(m[i].len));
                end
                chk("req_ready", i, 64'(req_ready[i]), 64'(er));
                chk("busy", i, 64'(busy[i]), 64'(m[i].busy));
                chk("idle", i, 64'(idle[i]),
                    64'(!m[i].pend && m[i].cnt == 0));
                chk("cpl_err", i, 64'(err[i]), 64'(m[i].err));
            end
        end
    end

    task automatic do_reset();
        @(negedge aclk);
        #3;
        aresetn = 1'b0;
        req_valid = '0; cmd_ready = '0; cpl_valid = 1'b0; prio = '0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    int order [$];
    int n1;

    initial begin
        for (int c = 0; c < N; c++) begin
            req_addr[c] = 32'h100 * (c + 1);
            req_len[c] = 8'(c + 2);
        end
        mreset(0); mreset(1);
        do_reset();
        chk_en = 1'b1;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_idle", i, 64'(idle[i]), 64'd1);
            chk("rst_busy", i, 64'(busy[i]), 64'd0);
            chk("rst_valid", i, 64'(cmd_valid[i]), 64'd0);
        end

        // Single request on channel 0, then drop req during ISSUE
        @(negedge aclk);
        req_valid = 4'b0001; req_addr[0] = 32'h1000; req_len[0] = 8'd7;
        cmd_ready = 2'b00;
        @(negedge aclk);
        #3;
        chk("d_valid", 0, 64'(cmd_valid[0]), 64'd1);
        chk("d_chn", 0, 64'(cchn[0]), 64'd0);
        chk("d_addr", 0, 64'(caddr[0]), 64'h1000);
        chk("d_len", 0, 64'(clen[0]), 64'd7);
        req_valid = '0;
        cmd_ready = 2'b11;
        #1;
        chk("d_ready", 0, 64'(req_ready[0]), 64'b0001);
        @(negedge aclk);
        #3;
        chk("d_busy", 0, 64'(busy[0]), 64'b0001);
        chk("d_busy", 1, 64'(busy[1]), 64'b0001);
        cpl_valid = 1'b1; cpl_chn = 2'd0;
        @(negedge aclk);
        cpl_valid = 1'b0;
        #3;
        chk("cpl_clr", 0, 64'(busy[0]), 64'd0);

        // Completion on an idle channel
        cpl_valid = 1'b1; cpl_chn = 2'd2;
        @(negedge aclk);
        cpl_valid = 1'b0;
        #3;
        chk("err_set", 0, 64'(err[0]), 64'd1);
        chk("err_idle", 0, 64'(idle[0]), 64'd1);

        // All four request: order 0..3 on dut0, two issues on dut1
        do_reset();
        @(negedge aclk);
        req_valid = 4'b1111; cmd_ready = 2'b11;
        n1 = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge aclk);
            #3;
            for (int c = 0; c < N; c++) begin
                if (req_ready[0][c]) order.push_back(c);
                if (req_ready[1][c]) n1++;
            end
        end
        chk("order_n", 0, 64'(order.size()), 64'd4);
        for (int k = 0; k < order.size(); k++)
            chk("order", 0, 64'(order[k]), 64'(k));
        chk("outstd_n", 1, 64'(n1), 64'd2);
        cpl_valid = 1'b1; cpl_chn = 2'd0;
        @(negedge aclk);
        cpl_valid = 1'b0;
        #3;
        chk("post_cpl0", 0, 64'(req_ready[0]), 64'd0);
        chk("post_cpl0", 1, 64'(req_ready[1]), 64'd0);
        @(negedge aclk);
        #3;
        chk("reissue", 0, 64'(req_ready[0]), 64'b0001);
        chk("third", 1, 64'(req_ready[1]), 64'b0100);

        // Reset while a command is stalled
        do_reset();
        @(negedge aclk);
        req_valid = 4'b0010; cmd_ready = 2'b00;
        @(negedge aclk);
        #3;
        chk("pre_rst", 0, 64'(cmd_valid[0]), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("ar_valid", 0, 64'(cmd_valid[0]), 64'd0);
        chk("ar_addr", 0, 64'(caddr[0]), 64'd0);
        chk("ar_idle", 0, 64'(idle[0]), 64'd1);
        cmd_ready = 2'b11;
        #1;
        chk("ar_ready", 0, 64'(req_ready[0]), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

`ifdef ADMA_SCHED_PRIO_EN
        do_reset();
        @(negedge aclk);
        prio = 4'b1000; req_valid = 4'b1111; cmd_ready = 2'b11;
        @(negedge aclk);
        #3;
        chk("prio_chn", 0, 64'(cchn[0]), 64'd3);
`endif

        // Randomised traffic
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            @(negedge aclk);
            req_valid = 4'($urandom);
            cmd_ready = 2'($urandom);
            prio = ($urandom % 4 == 0) ? 4'($urandom) : '0;
            for (int c = 0; c < N; c++) begin
                req_addr[c] = $urandom;
                req_len[c] = 8'($urandom);
            end
            cpl_valid = ($urandom % 3 == 0);
            cpl_chn = 2'($urandom);
            if (m[0].busy != '0 && $urandom % 8 != 0)
                for (int k = 0; k < 8; k++)
                    if (!m[0].busy[cpl_chn]) cpl_chn = 2'($urandom);
            if (t % 700 == 699) begin
                #3;
                aresetn = 1'b0;
                @(negedge aclk);
                aresetn = 1'b1;
            end
        end
        @(negedge aclk);
        cpl_valid = 1'b0;
        @(negedge aclk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/adma_chn_sched.md
ADMA_CHN_SCHED -- requirements
Module: adma_chn_sched

Interface
REQ-001 The block SHALL have parameter DST_CHANNEL_NUM, default 4: number of requesting destination channels.
REQ-002 The block SHALL have parameter ADDR_W, default 32: transfer address width.
REQ-003 The block SHALL have parameter TRANS_DATA_LEN_W, default 8: AXI burst length field width.
REQ-004 The block SHALL have parameter MAX_OUTSTD, default 4: maximum transfers in flight, range 1..DST_CHANNEL_NUM.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_valid_i, input, DST_CHANNEL_NUM bits: per-channel transfer request.
REQ-008 The block SHALL have port req_addr_i, input, ADDR_W per channel (unpacked array): per-channel source address.
REQ-009 The block SHALL have port req_len_i, input, TRANS_DATA_LEN_W per channel (unpacked array): per-channel burst length.
REQ-010 The block SHALL have port req_ready_o, output, DST_CHANNEL_NUM bits: one-cycle acceptance pulse for the issued channel.
REQ-011 The block SHALL have ports cmd_valid_o (output, 1), cmd_ready_i (input, 1), cmd_chn_o (output, CHN_ID_W), cmd_addr_o (output, ADDR_W) and cmd_len_o (output, TRANS_DATA_LEN_W): the command to the read host.
REQ-012 The block SHALL have ports cpl_valid_i (input, 1) and cpl_chn_i (input, CHN_ID_W): transfer completion from the write host.
REQ-013 The block SHALL have port busy_o, output, DST_CHANNEL_NUM bits: channel has a transfer in flight.
REQ-014 The block SHALL have port idle_o, output, 1 bit: the FSM is in IDLE and no transfer is outstanding.
REQ-015 The block SHALL have port cpl_err_o, output, 1 bit: sticky flag for a completion on a non-busy channel.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and ISSUE.
REQ-017 Eligible channels SHALL be req_valid_i & ~busy, and only while outstanding count < MAX_OUTSTD.
REQ-018 In IDLE, with any channel eligible, the block SHALL select one winner round-robin from rr_ptr, register that winner's id, address and length, and go to ISSUE.
REQ-019 In ISSUE, cmd_valid_o SHALL be 1, and the command payload SHALL stay stable until cmd_ready_i is 1.
REQ-020 On the cmd handshake, in the same cycle, the block SHALL pulse the winner's req_ready_o bit, set that channel's busy bit, increment the outstanding count, set rr_ptr to winner+1 (modulo DST_CHANNEL_NUM), and return to IDLE.
REQ-021 Latency SHALL be one cycle from an eligible request in IDLE to cmd_valid_o; peak throughput is one command every two cycles.
REQ-022 A cpl_valid_i on a busy channel SHALL clear that channel's busy bit and decrement the outstanding count.
REQ-023 A cpl_valid_i on a non-busy channel SHALL be ignored and SHALL set cpl_err_o until reset.
REQ-024 An issue and a completion in the same cycle SHALL leave the count unchanged; if both are for the same channel, busy SHALL end set.
REQ-025 A requester deasserting req_valid_i during ISSUE SHALL NOT abort the command; the command SHALL complete.
REQ-026 CHN_ID_W SHALL be $clog2(DST_CHANNEL_NUM), minimum 1.

Reset
REQ-027 aresetn low SHALL asynchronously force IDLE, rr_ptr=0, count=0, busy_o=0, req_ready_o=0, cmd_valid_o=0, cmd payload=0, cpl_err_o=0 and idle_o=1, including when asserted mid-ISSUE.

Configuration
REQ-028 With ADMA_SCHED_PRIO_EN defined, the block SHALL add input prio_i (DST_CHANNEL_NUM bits); any eligible channel with a prio bit set SHALL win over non-priority channels, with round-robin used within each class.
REQ-029 With ADMA_SCHED_PRIO_EN undefined, prio_i SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-030 Package adma_pkg SHALL hold the state enum, the CHN_ID_W derivation and the command struct (chn, addr, len).
REQ-031 The round-robin pick SHALL be the sub-module adma_rr_pick (request vector and pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-032 Reset, then req_valid_i=0001 with addr 0x1000 and len 7: cmd_valid_o=1 one cycle later with chn 0, addr 0x1000, len 7; after the handshake, busy_o=0001.
REQ-033 All four channels request with cmd_ready_i tied 1: issue order is 0,1,2,3; a completion then re-request on channel 0 issues 0 next.
REQ-034 MAX_OUTSTD=2 with four requests: exactly two issues; a third issues only in the cycle after a cpl_valid_i.
REQ-035 cpl_valid_i for channel 2 while busy_o=0000: cpl_err_o=1, count stays 0.
REQ-036 Drop aresetn while in ISSUE with cmd_ready_i=0: all outputs go to reset values immediately, and no req_ready_o pulse occurs.
REQ-037 With ADMA_SCHED_PRIO_EN defined, prio_i=1000 and all channels requesting: channel 3 issues first.
